// File: rtl/hpm_counter_unit_pkg.sv
// Shared constants, CSR address map and types for the HPM counter bank.
// decode_reg classifies a CSR address into the register kind it selects.
package hpm_counter_unit_pkg;

  localparam int HPM_FIRST_IDX                  = 3;
  localparam int HPM_MAX_COUNTERS               = 29;
  localparam int LOCAL_COUNT_OVERFLOW_INTERRUPT = 13;

  typedef struct packed {
    logic        of;
    logic [30:8] reserved;
    logic [7:0]  sel;
  } hpm_event_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CNT_LO,
    REG_CNT_HI,
    REG_EVENT,
    REG_INHIBIT,
    REG_SHADOW_LO,
    REG_SHADOW_HI
  } hpm_reg_e;

  // Each counter group occupies one 32-entry window, so addr[11:5] names the group.
  function automatic hpm_reg_e decode_reg(input logic [11:0] addr);
    logic is_ctr;
    hpm_reg_e r;
    is_ctr = (addr[4:0] >= 5'(HPM_FIRST_IDX));
    r      = REG_NONE;
    case (addr[11:5])
      7'h58: if (is_ctr) r = REG_CNT_LO;
      7'h5C: if (is_ctr) r = REG_CNT_HI;
      7'h60: if (is_ctr) r = REG_SHADOW_LO;
      7'h64: if (is_ctr) r = REG_SHADOW_HI;
      7'h19: begin
        if (addr[4:0] == 5'd0) r = REG_INHIBIT;
        else if (is_ctr)       r = REG_EVENT;
      end
      default: r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hpm_counter_unit_if.sv
// CSR access bus between the CSR unit (master) and the HPM counter bank (slave).
interface hpm_counter_unit_if;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  modport master (output csr_addr, csr_we, csr_wdata, input  csr_rdata, csr_hit);
  modport slave  (input  csr_addr, csr_we, csr_wdata, output csr_rdata, csr_hit);
endinterface

// File: rtl/hpm_counter_unit_hpm_counter.sv
// One HPM counter slice: event select, inhibit, software write merge and
// overflow detection. Software writes always take precedence over counting.
module hpm_counter
  import hpm_counter_unit_pkg::*;
#(
  parameter int COUNTER_W  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events_q_i,
  input  logic                  inhibit_i,
  input  logic                  we_lo_i,
  input  logic                  we_hi_i,
  input  logic                  we_evt_i,
  input  logic [31:0]           wdata_i,
  output logic [COUNTER_W-1:0]  cnt_o,
  output hpm_event_t            evt_o,
  output logic                  ovf_set_o
);

  localparam logic [8:0] NEV = 9'(NUM_EVENTS);

  logic [COUNTER_W-1:0] cnt_q, cnt_d;
  logic [7:0]           sel_q, sel_d;
  logic                 of_q, of_d;
  logic [255:0]         ev_ext;
  logic                 sel_valid, inc, wrap;

  // Widen the event vector so any 8-bit selector indexes it safely.
  assign ev_ext    = 256'(events_q_i);
  assign sel_valid = (sel_q != 8'd0) && ({1'b0, sel_q} <= NEV);
  assign inc       = sel_valid && ev_ext[sel_q - 8'd1] && !inhibit_i && !we_lo_i && !we_hi_i;
  assign wrap      = inc && (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i)      cnt_d[31:0]           = wdata_i;
    else if (we_hi_i) cnt_d[COUNTER_W-1:32] = wdata_i[COUNTER_W-33:0];
    else if (inc)     cnt_d                 = cnt_q + COUNTER_W'(1);
  end

  always_comb begin
    sel_d = sel_q;
    of_d  = of_q;
    if (we_evt_i) begin
      sel_d = wdata_i[7:0];
      of_d  = wdata_i[31];
    end else if (wrap) begin
      of_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
      of_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      of_q  <= of_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign evt_o     = '{of: of_q, reserved: '0, sel: sel_q};
  assign ovf_set_o = wrap && !of_q && !we_evt_i;

endmodule

// File: rtl/hpm_counter_unit.sv
// Bank of machine HPM counters with event selectors, inhibit and
// local-count-overflow interrupt; decodes CSR accesses forwarded by the CSR unit.
module hpm_counter_unit
  import hpm_counter_unit_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 64,
  parameter int NUM_EVENTS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  hpm_counter_unit_if.slave     csr,
  output logic                  lcof_pending,
  output logic                  lcof_irq
);

  localparam logic [31:0] INH_MASK =
    32'(((64'd1 << NUM_COUNTERS) - 64'd1) << HPM_FIRST_IDX);

  logic [NUM_EVENTS-1:0]   events_q;
  logic [31:0]             inhibit_q, inhibit_d;
  logic                    irq_q;
  hpm_reg_e                reg_sel;
  logic [4:0]              idx;
  logic [31:0]             rdata;
  logic [COUNTER_W-1:0]    cnt [NUM_COUNTERS];
  hpm_event_t              evt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] we_lo, we_hi, we_evt, of_vec, ovf_set;

  assign reg_sel = decode_reg(csr.csr_addr);
  assign idx     = csr.csr_addr[4:0];

  always_comb begin
    inhibit_d = inhibit_q;
    if (csr.csr_we && reg_sel == REG_INHIBIT) inhibit_d = csr.csr_wdata & INH_MASK;
  end

  // Stage 1 registers the event strobes; counters update one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      events_q  <= '0;
      inhibit_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      events_q  <= events;
      inhibit_q <= inhibit_d;
      irq_q     <= |ovf_set;
    end
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ctr
    localparam logic [4:0] CIDX = 5'(g + HPM_FIRST_IDX);

    assign we_lo[g]  = csr.csr_we && (reg_sel == REG_CNT_LO) && (idx == CIDX);
    assign we_hi[g]  = csr.csr_we && (reg_sel == REG_CNT_HI) && (idx == CIDX);
    assign we_evt[g] = csr.csr_we && (reg_sel == REG_EVENT)  && (idx == CIDX);
    assign of_vec[g] = evt[g].of;

    hpm_counter #(
      .COUNTER_W (COUNTER_W),
      .NUM_EVENTS(NUM_EVENTS)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .events_q_i(events_q),
      .inhibit_i (inhibit_q[g + HPM_FIRST_IDX]),
      .we_lo_i   (we_lo[g]),
      .we_hi_i   (we_hi[g]),
      .we_evt_i  (we_evt[g]),
      .wdata_i   (csr.csr_wdata),
      .cnt_o     (cnt[g]),
      .evt_o     (evt[g]),
      .ovf_set_o (ovf_set[g])
    );
  end

  // Unimplemented counter indices fall through the loop and read as zero.
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NUM_COUNTERS; j++) begin
      if (idx == 5'(j + HPM_FIRST_IDX)) begin
        case (reg_sel)
          REG_CNT_LO, REG_SHADOW_LO: rdata = cnt[j][31:0];
          REG_CNT_HI, REG_SHADOW_HI: rdata = 32'(cnt[j][COUNTER_W-1:32]);
          REG_EVENT:                 rdata = evt[j];
          default:                   rdata = rdata;
        endcase
      end
    end
    if (reg_sel == REG_INHIBIT) rdata = inhibit_q;
  end

  assign csr.csr_rdata = rdata;
  assign csr.csr_hit   = (reg_sel != REG_NONE);
  assign lcof_pending  = |of_vec;
  assign lcof_irq      = irq_q;

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Directed bench for hpm_counter_unit with a behavioural reference model
// compared against the DUT on every falling clock edge.
module tb_hpm_counter_unit;

  localparam int NC = 4;
  localparam int CW = 64;
  localparam int NE = 16;
  localparam longint unsigned MASK = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - CW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] events = '0;
  logic          lcof_pending, lcof_irq;

  hpm_counter_unit_if bus ();

  hpm_counter_unit #(
    .NUM_COUNTERS(NC),
    .COUNTER_W   (CW),
    .NUM_EVENTS  (NE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .events      (events),
    .csr         (bus),
    .lcof_pending(lcof_pending),
    .lcof_irq    (lcof_irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: architectural registers indexed by CSR counter number.
  longint unsigned m_cnt [32];
  logic [7:0]      m_sel [32];
  logic [31:0]     m_of;
  logic [31:0]     m_inh;
  logic [NE-1:0]   m_evq;
  logic            m_irq;

  always @(posedge clk or posedge rst) begin
    bit counted, any_new, wr_lo, wr_hi, wr_ev;
    int s;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_cnt[i] <= 0;
        m_sel[i] <= 8'd0;
      end
      m_of  <= '0;
      m_inh <= '0;
      m_evq <= '0;
      m_irq <= 1'b0;
    end else begin
      any_new = 0;
      m_evq <= events;
      for (int i = 3; i < 3 + NC; i++) begin
        s       = int'(m_sel[i]);
        counted = (m_inh[i] == 1'b0) && (s >= 1) && (s <= NE) && (m_evq[(s >= 1) ? s - 1 : 0] == 1'b1);
        wr_lo   = bus.csr_we && (bus.csr_addr == 12'(12'hB00 + i));
        wr_hi   = bus.csr_we && (bus.csr_addr == 12'(12'hB80 + i));
        wr_ev   = bus.csr_we && (bus.csr_addr == 12'(12'h320 + i));
        if (wr_lo)
          m_cnt[i] <= (m_cnt[i] & ~64'h0000_0000_FFFF_FFFF) | 64'(bus.csr_wdata);
        else if (wr_hi)
          m_cnt[i] <= ((m_cnt[i] & 64'h0000_0000_FFFF_FFFF) | (64'(bus.csr_wdata) << 32)) & MASK;
        else if (counted) begin
          m_cnt[i] <= (m_cnt[i] + 1) & MASK;
          if (m_cnt[i] == MASK) begin
            if (!m_of[i] && !wr_ev) any_new = 1;
            m_of[i] <= 1'b1;
          end
        end
        if (wr_ev) begin
          m_sel[i] <= bus.csr_wdata[7:0];
          m_of[i]  <= bus.csr_wdata[31];
        end
      end
      if (bus.csr_we && bus.csr_addr == 12'h320)
        m_inh <= bus.csr_wdata & 32'h0000_0078;
      m_irq <= any_new;
    end
  end

  function automatic void exp_read(input logic [11:0] a, output logic [31:0] d, output logic h);
    int  i    = int'(a[4:0]);
    bit  impl = (i >= 3) && (i < 3 + NC);
    d = '0;
    h = 1'b0;
    if ((a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hC03 && a <= 12'hC1F)) begin
      h = 1'b1;
      if (impl) d = 32'(m_cnt[i]);
    end else if ((a >= 12'hB83 && a <= 12'hB9F) || (a >= 12'hC83 && a <= 12'hC9F)) begin
      h = 1'b1;
      if (impl) d = 32'(m_cnt[i] >> 32);
    end else if (a == 12'h320) begin
      h = 1'b1;
      d = m_inh;
    end else if (a >= 12'h323 && a <= 12'h33F) begin
      h = 1'b1;
      if (impl) d = {m_of[i], 23'd0, m_sel[i]};
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] ed;
    logic        eh;
    exp_read(bus.csr_addr, ed, eh);
    checks++;
    if (bus.csr_rdata !== ed || bus.csr_hit !== eh) begin
      failures++;
      $display("FAIL model_read addr=%h got rdata=%h hit=%b want rdata=%h hit=%b",
               bus.csr_addr, bus.csr_rdata, bus.csr_hit, ed, eh);
    end
    checks++;
    if (lcof_pending !== (|m_of)) begin
      failures++;
      $display("FAIL model_pending got=%b want=%b", lcof_pending, |m_of);
    end
    checks++;
    if (lcof_irq !== m_irq) begin
      failures++;
      $display("FAIL model_irq got=%b want=%b", lcof_irq, m_irq);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    bus.csr_we    = 1'b1;
    tick();
    bus.csr_we    = 1'b0;
  endtask

  // Reads stay clear of the falling edge so the continuous compare never races an address change.
  task automatic check_read(input string nm, input logic [11:0] a, input logic [31:0] e, input logic eh);
    if (($time % 10) < 6 || ($time % 10) > 8) tick();
    bus.csr_addr = a;
    #1;
    checks++;
    if (bus.csr_rdata !== e || bus.csr_hit !== eh) begin
      failures++;
      $display("FAIL %s addr=%h got rdata=%h hit=%b want rdata=%h hit=%b",
               nm, a, bus.csr_rdata, bus.csr_hit, e, eh);
    end
  endtask

  task automatic check_sig(input string nm, input logic act, input logic e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, e);
    end
  endtask

  initial begin
    bus.csr_addr  = 12'h000;
    bus.csr_we    = 1'b0;
    bus.csr_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_read("rst_cnt3_lo", 12'hB03, 32'h0, 1'b1);
    check_read("rst_cnt3_hi", 12'hB83, 32'h0, 1'b1);
    check_read("rst_evt3",    12'h323, 32'h0, 1'b1);
    check_read("rst_inhibit", 12'h320, 32'h0, 1'b1);
    check_read("unimpl_cnt31", 12'hB1F, 32'h0, 1'b1);
    check_read("no_hit_7c0",  12'h7C0, 32'h0, 1'b0);
    check_sig("rst_pending", lcof_pending, 1'b0);
    check_sig("rst_irq", lcof_irq, 1'b0);

    // Basic counting and two-cycle visibility
    csr_write(12'h323, 32'h0000_0002);
    bus.csr_addr = 12'hB03;
    events = 16'h0002;
    tick();
    check_read("lat_n1", 12'hB03, 32'd0, 1'b1);
    tick();
    check_read("lat_n2", 12'hB03, 32'd1, 1'b1);
    tick(); tick(); tick();
    events = '0;
    tick(); tick();
    check_read("count5",       12'hB03, 32'd5, 1'b1);
    check_read("shadow_count", 12'hC03, 32'd5, 1'b1);
    check_read("cnt4_sel0",    12'hB04, 32'd0, 1'b1);

    // Inhibit and out-of-range selectors
    csr_write(12'h320, 32'h0000_0008);
    check_read("inhibit_rd", 12'h320, 32'h8, 1'b1);
    events = 16'h0002;
    tick(); tick(); tick();
    events = '0;
    tick(); tick(); tick();
    check_read("inhibited", 12'hB03, 32'd5, 1'b1);
    csr_write(12'h320, 32'hFFFF_FFFF);
    check_read("inhibit_mask", 12'h320, 32'h78, 1'b1);
    csr_write(12'h320, 32'h0);
    events = 16'h0002;
    tick();
    events = '0;
    tick(); tick(); tick();
    check_read("uninhibited", 12'hB03, 32'd6, 1'b1);
    csr_write(12'h323, 32'h0000_00C8);
    events = 16'hFFFF;
    tick(); tick();
    events = '0;
    tick(); tick();
    check_read("sel_big_rd",  12'h323, 32'h0000_00C8, 1'b1);
    check_read("sel_big_cnt", 12'hB03, 32'd6, 1'b1);
    csr_write(12'h323, 32'h0000_0002);

    // Overflow, single IRQ pulse, OF clear
    csr_write(12'hB83, 32'hFFFF_FFFF);
    csr_write(12'hB03, 32'hFFFF_FFFE);
    events = 16'h0002;
    tick(); tick();
    events = '0;
    check_read("pre_wrap", 12'hB03, 32'hFFFF_FFFF, 1'b1);
    check_sig("pre_wrap_irq", lcof_irq, 1'b0);
    tick();
    check_read("wrap_lo", 12'hB03, 32'h0, 1'b1);
    check_read("wrap_hi", 12'hB83, 32'h0, 1'b1);
    check_read("wrap_of", 12'h323, 32'h8000_0002, 1'b1);
    check_sig("wrap_irq", lcof_irq, 1'b1);
    check_sig("wrap_pending", lcof_pending, 1'b1);
    tick();
    check_sig("irq_one_cycle", lcof_irq, 1'b0);
    check_sig("pending_held", lcof_pending, 1'b1);
    csr_write(12'h323, 32'h0000_0002);
    check_sig("of_cleared", lcof_pending, 1'b0);

    // Software-set OF: no pulse, and a second overflow with OF set stays silent
    csr_write(12'h323, 32'h8000_0002);
    check_sig("sw_of_pending", lcof_pending, 1'b1);
    check_sig("sw_of_no_irq", lcof_irq, 1'b0);
    csr_write(12'hB83, 32'hFFFF_FFFF);
    csr_write(12'hB03, 32'hFFFF_FFFF);
    events = 16'h0002;
    tick();
    events = '0;
    tick();
    check_sig("rewrap_no_irq", lcof_irq, 1'b0);
    check_read("rewrap_cnt", 12'hB03, 32'h0, 1'b1);
    check_read("rewrap_of",  12'h323, 32'h8000_0002, 1'b1);
    csr_write(12'h323, 32'h0000_0002);

    // Write beats a same-cycle increment; shadows and unimplemented slots ignore writes
    events = 16'h0002;
    tick();
    events = '0;
    csr_write(12'hB03, 32'h0000_0100);
    tick();
    check_read("write_wins", 12'hB03, 32'h0000_0100, 1'b1);
    csr_write(12'hC03, 32'h0000_DEAD);
    csr_write(12'hB1F, 32'h0000_BEEF);
    check_read("shadow_ro",  12'hB03, 32'h0000_0100, 1'b1);
    check_read("unimpl_ro",  12'hB1F, 32'h0, 1'b1);

    // Asynchronous reset mid-count
    csr_write(12'h324, 32'h0000_0002);
    events = 16'h0002;
    tick(); tick(); tick();
    rst = 1'b1;
    check_read("arst_cnt3", 12'hB03, 32'h0, 1'b1);
    check_read("arst_cnt4", 12'hB04, 32'h0, 1'b1);
    check_read("arst_evt3", 12'h323, 32'h0, 1'b1);
    check_sig("arst_pending", lcof_pending, 1'b0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check_read("post_rst_idle", 12'hB03, 32'h0, 1'b1);
    csr_write(12'h323, 32'h0000_0002);
    tick(); tick(); tick();
    check_read("resume_cnt3", 12'hB03, 32'd3, 1'b1);
    check_read("resume_cnt4", 12'hB04, 32'd0, 1'b1);
    events = '0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpm_counter_unit.md
Name: hpm_counter_unit

Overview:
- Parametrised bank of machine hardware performance-monitor counters: mhpmcounter3..(3+NUM_COUNTERS-1), their high halves, the matching mhpmevent selectors, and the mcountinhibit bits.
- Supports Sscofpmf-style overflow flags and raises the local-count-overflow interrupt (cause 13).
- Sits beside the CSR unit, which decodes privilege and forwards raw CSR address, data and strobes.
- Generalises the fixed cycle/instret counters to N configurable-width, event-selectable channels.

Parameters:
- NUM_COUNTERS, 4, number of implemented HPM counters (1..29); counters 3+NUM_COUNTERS..31 read as zero.
- COUNTER_W, 64, counter width (33..64); upper bits above COUNTER_W read as zero.
- NUM_EVENTS, 16, number of event inputs (1..255); event selector value 0 means "no event".

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- events  in  NUM_EVENTS  per-cycle event strobes; bit k is event selector k+1
- csr_addr  in  12  CSR address
- csr_we  in  1  write strobe (final value already computed by the CSR unit for RW/RS/RC)
- csr_wdata  in  32  write data
- csr_rdata  out  32  combinational read data for csr_addr
- csr_hit  out  1  csr_addr belongs to this block
- lcof_pending  out  1  OR of all OF bits
- lcof_irq  out  1  one-cycle pulse when any OF bit goes 0->1

Behaviour:
- Reset (async, rst=1): all counters 0, all mhpmevent 0, inhibit bits 0, OF bits 0, event register 0, lcof_irq 0. Reset mid-count discards all state immediately.
- Address map, counter i = 3..31:
  - MHPMCOUNTERi 0xB00+i: low 32 bits.
  - MHPMCOUNTERiH 0xB80+i: bits COUNTER_W-1:32.
  - MHPMEVENTi 0x320+i: OF at bit 31, selector at bits 7:0.
  - MCOUNTINHIBIT 0x320: only bits 3..3+NUM_COUNTERS-1 are writable.
  - User shadows HPMCOUNTERi 0xC00+i and HPMCOUNTERiH 0xC80+i are read-only; writes to them are ignored.
  - csr_hit=1 for every address above, including unimplemented counter indices. Those indices read 0 and ignore writes.
- Pipeline:
  - events is registered (stage 1).
  - Counter i increments on the next edge (stage 2) if all hold: the registered event bit for sel_i-1 is set, sel_i is in 1..NUM_EVENTS, and inhibit[i]=0.
  - An event strobe in cycle N is visible on csr_rdata in cycle N+2.
  - Selector values above NUM_EVENTS never count. They are stored as written and read back.
- Increment is +1 per cycle per counter; at most one event is counted per counter per cycle.
- Write vs increment in the same cycle: the write wins and the increment is lost.
  - Low-half write sets bits 31:0 and keeps the upper bits.
  - High-half write sets bits COUNTER_W-1:32 from wdata[COUNTER_W-33:0].
- Overflow: a counter at all-ones that increments wraps to 0.
  - If OF_i=0, set OF_i and assert lcof_irq for exactly one cycle.
  - If OF_i was already 1, it stays 1 and no pulse is generated.
  - Multiple simultaneous overflows produce a single pulse.
- OF_i is cleared or set only by software via a MHPMEVENTi write (bit 31).
  - A software write that sets OF does not pulse lcof_irq.
  - If a write and an overflow hit the same counter in the same cycle, the write determines OF.
- lcof_pending = |OF, registered-state based with no added latency.
- Inhibit takes effect at stage 2 using the current register value.

Decomposition:
- Shared riscv_types package:
  - HPM_FIRST_IDX=3 and HPM_MAX_COUNTERS=29 constants.
  - Packed struct hpm_event_t {of, reserved[30:8], sel[7:0]}.
  - LOCAL_COUNT_OVERFLOW_INTERRUPT, which already exists there.
- Sub-module hpm_counter:
  - One counter slice with event mux, inhibit, write merge and overflow detect.
  - Instantiated NUM_COUNTERS times via generate.
  - The top level handles address decode, read mux and the IRQ OR/edge.

Test Plan:
- Reset then read 0xB03, 0xB83, 0x323, 0x320 -> all 0, csr_hit=1. Read 0xB1F with NUM_COUNTERS=4 -> 0, hit=1. Read 0x7C0 -> hit=0.
- Write 0x323=0x00000002, pulse events[1] for 5 cycles -> mhpmcounter3 reads 5, visible 2 cycles after the first strobe. mhpmcounter4 (sel 0) stays 0.
- Set mcountinhibit=0x8, then pulse the selected event 3 cycles -> counter3 unchanged. Clear inhibit, pulse 1 cycle -> counter3 increments by 1.
- Write 0xB83=0xFFFFFFFF and 0xB03=0xFFFFFFFE, then count 2 events -> counter=0. OF3 reads 1 (0x323 bit 31), lcof_irq high exactly one cycle, lcof_pending=1. Write 0x323 with bit 31=0 -> lcof_pending=0.
- Write 0xB03=0x100 in the same cycle as a counted event -> reads 0x100, not 0x101.
- Assert rst mid-count with counters nonzero -> all outputs and registers 0 asynchronously. Counting resumes only after the selectors are rewritten.
